// File: rtl/pb_switch_port.sv
// ============================================================================
// Module   : pb_switch_port
// Brief    : Debounced 8-bit slide-switch input port for PicoBlaze with sticky
//            change flags, overflow status, event counter and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_switch_port #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port,
    output logic       interrupt
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]            r_sync1;
    logic [7:0]            r_sync2;
    logic [7:0]            r_stable;
    logic [7:0][CNT_W-1:0] r_cnt;
    logic [7:0]            r_flags;
    logic                  r_overflow;
    logic [7:0]            r_evcount;

    logic [7:0] w_diff;
    logic [7:0] w_event;
    logic       w_flag_clr;
    logic       w_ovf_clr;
    logic       w_ovf_set;
    logic       w_unused_port_id;

    // A bit's event fires on the last cycle of a full run of differing samples.
    always_comb begin
        w_diff  = r_sync2 ^ r_stable;
        w_event = '0;
        for (int i = 0; i < 8; i++) begin
            w_event[i] = w_diff[i] && (r_cnt[i] == c_limit);
        end
    end

    assign w_flag_clr       = read_strobe && (port_id[1:0] == 2'b01);
    assign w_ovf_clr        = read_strobe && (port_id[1:0] == 2'b10);
    assign w_ovf_set        = |(w_event & r_flags);
    assign w_unused_port_id = &{1'b0, port_id[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_cnt      <= '0;
            r_flags    <= '0;
            r_overflow <= 1'b0;
            r_evcount  <= '0;
            in_port    <= '0;
            interrupt  <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;

            for (int i = 0; i < 8; i++) begin
                if (!w_diff[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_event[i]) begin
                    r_cnt[i]    <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

            // Set beats clear for both the flags and the overflow bit.
            r_flags    <= (w_flag_clr ? 8'h00 : r_flags) | w_event;
            r_overflow <= w_ovf_set | (r_overflow & ~w_ovf_clr);

            if (|w_event) begin
                r_evcount <= r_evcount + 8'd1;
            end

            if (|w_event) begin
                interrupt <= 1'b1;
            end else if (interrupt_ack) begin
                interrupt <= 1'b0;
            end

            case (port_id[1:0])
                2'b00:   in_port <= r_stable;
                2'b01:   in_port <= r_flags;
                2'b10:   in_port <= {6'b0, r_overflow, |r_flags};
                default: in_port <= r_evcount;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pb_switch_port.sv
// ============================================================================
// Module   : tb_pb_switch_port
// Brief    : Directed, table-driven self-checking bench for pb_switch_port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_switch_port;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;

    int n_checks;
    int n_fail;

    pb_switch_port #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .interrupt_ack(interrupt_ack),
        .in_port      (in_port),
        .interrupt    (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] pid;
        logic       rs;
        logic       ack;
        int         n;
        logic [7:0] exp_in;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[28];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // rs/ack are pulsed for the first cycle only; checks are taken after n cycles.
    task automatic apply_vec(input int idx);
        vec_t v;
        v             = vecs[idx];
        sw            = v.sw;
        port_id       = v.pid;
        read_strobe   = v.rs;
        interrupt_ack = v.ack;
        step();
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        repeat (v.n - 1) step();
        check8($sformatf("vec%0d in_port", idx), in_port, v.exp_in);
        check8($sformatf("vec%0d interrupt", idx), {7'b0, interrupt}, {7'b0, v.exp_irq});
    endtask

    logic [7:0] sw_val;
    int         ev_model;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            sw     pid    rs    ack   n   in_port irq
        vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 10, 8'h00, 1'b0};
        vecs[1]  = '{8'h00, 8'h03, 1'b0, 1'b0, 2,  8'h00, 1'b0};
        vecs[2]  = '{8'h05, 8'h00, 1'b0, 1'b0, 6,  8'h00, 1'b1};
        vecs[3]  = '{8'h05, 8'h00, 1'b0, 1'b0, 1,  8'h05, 1'b1};
        vecs[4]  = '{8'h05, 8'h01, 1'b0, 1'b0, 2,  8'h05, 1'b1};
        vecs[5]  = '{8'h05, 8'h03, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        vecs[6]  = '{8'h05, 8'h02, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        vecs[7]  = '{8'h0D, 8'h00, 1'b0, 1'b0, 3,  8'h05, 1'b1};
        vecs[8]  = '{8'h05, 8'h00, 1'b0, 1'b0, 8,  8'h05, 1'b1};
        vecs[9]  = '{8'h05, 8'h01, 1'b0, 1'b0, 2,  8'h05, 1'b1};
        vecs[10] = '{8'h05, 8'h03, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        vecs[11] = '{8'h05, 8'h00, 1'b1, 1'b0, 2,  8'h05, 1'b1};
        vecs[12] = '{8'h05, 8'h03, 1'b1, 1'b0, 2,  8'h01, 1'b1};
        vecs[13] = '{8'h05, 8'h01, 1'b0, 1'b0, 2,  8'h05, 1'b1};
        vecs[14] = '{8'h05, 8'h02, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        // after the same-cycle read/event sequence: stable=07 flags=02 evcount=2
        vecs[15] = '{8'h07, 8'h00, 1'b0, 1'b0, 2,  8'h07, 1'b1};
        vecs[16] = '{8'h07, 8'h03, 1'b0, 1'b0, 2,  8'h02, 1'b1};
        vecs[17] = '{8'h07, 8'h02, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        vecs[18] = '{8'h07, 8'h00, 1'b0, 1'b1, 2,  8'h07, 1'b0};
        vecs[19] = '{8'h07, 8'h02, 1'b0, 1'b0, 2,  8'h01, 1'b0};
        vecs[20] = '{8'h06, 8'h02, 1'b0, 1'b0, 8,  8'h01, 1'b1};
        vecs[21] = '{8'h07, 8'h02, 1'b0, 1'b0, 8,  8'h03, 1'b1};
        vecs[22] = '{8'h07, 8'h03, 1'b0, 1'b0, 2,  8'h04, 1'b1};
        vecs[23] = '{8'h07, 8'h02, 1'b1, 1'b0, 1,  8'h03, 1'b1};
        vecs[24] = '{8'h07, 8'h02, 1'b0, 1'b0, 2,  8'h01, 1'b1};
        vecs[25] = '{8'h07, 8'h01, 1'b0, 1'b0, 2,  8'h03, 1'b1};
        vecs[26] = '{8'h07, 8'h01, 1'b1, 1'b0, 2,  8'h00, 1'b1};
        vecs[27] = '{8'h07, 8'h02, 1'b0, 1'b0, 2,  8'h00, 1'b1};

        rst_n         = 1'b0;
        sw            = 8'h00;
        port_id       = 8'h00;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
        repeat (3) step();
        check8("reset in_port", in_port, 8'h00);
        check8("reset interrupt", {7'b0, interrupt}, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i <= 14; i++) apply_vec(i);

        // Flag read lands on the same edge as a bit-1 change event.
        sw          = 8'h07;
        port_id     = 8'h01;
        read_strobe = 1'b0;
        repeat (5) step();
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        check8("rd01 old flags", in_port, 8'h05);
        repeat (2) step();
        check8("flags after set-wins", in_port, 8'h02);

        for (int i = 15; i <= 27; i++) apply_vec(i);

        // Drive evcount (now 4) through the 8'hFF -> 8'h00 wrap; the first
        // change moves two bits at once and must count as a single event.
        ev_model = 4;
        sw_val   = 8'h07;
        port_id  = 8'h00;
        for (int i = 0; i < 252; i++) begin
            sw_val = sw_val ^ ((i == 0) ? 8'hC0 : 8'h01);
            sw     = sw_val;
            if (i == 251) begin
                repeat (5) step();
                interrupt_ack = 1'b1;
                step();
                interrupt_ack = 1'b0;
                check8("ack vs event irq", {7'b0, interrupt}, 8'h01);
                repeat (2) step();
            end else begin
                repeat (8) step();
            end
            ev_model = (ev_model + 1) & 8'hFF;
            if (i == 0) begin
                port_id = 8'h03;
                repeat (2) step();
                check8("dual-bit event count", in_port, 8'h05);
                port_id = 8'h00;
            end
        end
        port_id = 8'h03;
        repeat (2) step();
        check8("evcount wrap", in_port, 8'(ev_model));
        port_id = 8'h00;
        repeat (2) step();
        check8("stable after loop", in_port, sw_val);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        check8("ack clears irq", {7'b0, interrupt}, 8'h00);

        // Reset mid-debounce, then release with switches held high.
        sw_val = sw_val ^ 8'h01;
        sw     = sw_val;
        repeat (4) step();
        rst_n = 1'b0;
        #2;
        check8("async reset in_port", in_port, 8'h00);
        check8("async reset irq", {7'b0, interrupt}, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check8("held reset port", in_port, 8'h00);
        repeat (7) step();
        check8("post-reset stable", in_port, sw_val);
        check8("post-reset irq", {7'b0, interrupt}, 8'h01);
        port_id = 8'h03;
        repeat (2) step();
        check8("post-reset evcount", in_port, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
